controller_state_sequencer: RTL and testbench
=============================================

// Module: controller_state_sequencer
// PURPOSE
// - State register and Moore control-output decoder for the multicycle controller; consumes next_state from the next-state logic, feeds current_state back to it.
// - Holds the FSM in memory states (S0 fetch, S3 LW read, S5 SW write) until the memory handshake completes.
// - Drives datapath strobes, a halt flag and a sticky illegal-state flag; optional perf counters.
// PARAMETERS
// - CNT_W  16  width of the perf counters (used only with SEQ_PERF_CNT_EN)
// PORTS
// - clk            in   1      single clock, rising edge
// - rst_n          in   1      asynchronous active-low reset
// - next_state     in   state_t  proposed next state (FSMStateData, 4-bit, S0..S11)
// - mem_ready      in   1      memory completes the current access this cycle
// - current_state  out  state_t  registered state
// - mem_read       out  1      memory read request
// - mem_write      out  1      memory write request
// - iord           out  1      0 = address from PC, 1 = address from ALUOut
// - ir_write       out  1      load instruction register
// - mdr_write      out  1      load memory data register
// - ab_write       out  1      latch register-file A/B operands
// - aluout_write   out  1      latch ALUOut
// - alu_src_b      out  1      0 = register B, 1 = sign-extended immediate
// - alu_op         out  2      00 ADD, 01 SUB, 10 FUNCT (ADD/SUB/MULT from opcode), 11 SLT
// - reg_write      out  1      register-file write enable
// - mem_to_reg     out  1      write-back source: 1 = MDR, 0 = ALU/ALUOut
// - pc_write       out  1      unconditional PC load
// - pc_write_cond  out  1      PC load if ALU zero (BEQ)
// - pc_src         out  2      00 PC+1, 01 ALUOut (branch target), 10 jump target
// - halted         out  1      high while in S11
// - illegal_state  out  1      sticky: next_state outside S0..S11 was seen
// - cycle_cnt      out  CNT_W  cycles spent outside S11 (macro only)
// - instr_cnt      out  CNT_W  instructions retired (macro only)
// BEHAVIOUR
// - Reset (async assert, sync-release): current_state=S0, illegal_state=0, counters=0; outputs are the S0 decode (mem_read=1, every other strobe 0 until mem_ready).
// - Update each edge: if current_state in {S0,S3,S5} and mem_ready=0 -> hold; else load next_state.
// - Illegal input: next_state not in S0..S11 -> load S11, set illegal_state (cleared only by reset).
// - Outputs are purely decoded from current_state (plus mem_ready where noted); unlisted = 0, alu_op=00, pc_src=00, iord=0.
// -   S0 FETCH : mem_read; ir_write=pc_write=mem_ready; alu_src_b=0 with alu_op=00 (PC+1 path), pc_src=00.
// -   S1 DECODE: ab_write.
// -   S2 ADDR  : alu_src_b=1, alu_op=00, aluout_write.
// -   S3 LW MEM: mem_read, iord, mdr_write=mem_ready.
// -   S4 LW WB : reg_write, mem_to_reg.
// -   S5 SW MEM: mem_write, iord (held until mem_ready).
// -   S6 ALU EX: alu_op=10, aluout_write.
// -   S7 ALU WB: reg_write, mem_to_reg=0.
// -   S8 SLT   : alu_op=11, reg_write.
// -   S9 JUMP  : pc_write, pc_src=10.
// -   S10 BEQ  : alu_op=01, pc_write_cond, pc_src=01.
// -   S11 HALT : halted=1, all strobes 0; leaves only via reset.
// - Strobes are level, one cycle per state; a stall in S0/S3/S5 keeps mem_read/mem_write/iord asserted, write enables gated by mem_ready so each fires exactly once.
// - Reset asserted mid-stall or mid-instruction: immediate return to S0, no partial write strobe after reset edge.
// CONFIGURATION
// - SEQ_PERF_CNT_EN defined: cycle_cnt +1 every cycle current_state!=S11; instr_cnt +1 on each edge leaving S4,S5,S7,S8,S9,S10 into S0 (S5 counts only when mem_ready); both saturate at 2^CNT_W-1 (no wrap).
// - SEQ_PERF_CNT_EN undefined: counters not instantiated, cycle_cnt and instr_cnt tied to 0.
// TESTING
// - Reset with mem_ready=1, next_state=S1 -> current_state=S0, mem_read=1, ir_write=1, pc_write=1; next edge current_state=S1, ab_write=1.
// - ADD path S0->S1->S6->S7->S0, mem_ready=1 -> alu_op=10 in S6, reg_write=1 & mem_to_reg=0 in S7; instr_cnt=1, cycle_cnt=4 (macro on).
// - LW in S3 with mem_ready=0 for 3 cycles then 1 -> state held 3 cycles, mdr_write only in the 4th, then S4 with reg_write=1 & mem_to_reg=1.
// - next_state=4'hF from S1 -> S11, illegal_state=1, halted=1, all strobes 0; stays S11 with any next_state until rst_n=0.
// - rst_n pulsed low during S5 stall -> current_state=S0 asynchronously, mem_write=0, illegal_state and counters 0.
// - CNT_W=4, macro on, 20 single-cycle-retire loops -> instr_cnt=15 (saturated); macro off -> counters read 0 throughout.

Source files
------------

// File: rtl/controller_state_sequencer.sv
// State register and Moore strobe decoder for the multicycle controller.
// Define SEQ_PERF_CNT_EN to build the saturating cycle/instruction counters.
module controller_state_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       next_state,
  input  logic             mem_ready,
  output logic [3:0]       current_state,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             ab_write,
  output logic             aluout_write,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic             illegal_state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  // state | meaning
  // S0    | fetch, wait for memory
  // S1    | decode, latch A/B
  // S2    | LW/SW address compute
  // S3    | LW memory read, wait for memory
  // S4    | LW write-back
  // S5    | SW memory write, wait for memory
  // S6    | ALU execute
  // S7    | ALU write-back
  // S8    | SLT
  // S9    | jump
  // S10   | BEQ
  // S11   | halt, exits only through reset
  localparam logic [3:0] S0  = 4'd0,  S1  = 4'd1,  S2 = 4'd2, S3 = 4'd3,
                         S4  = 4'd4,  S5  = 4'd5,  S6 = 4'd6, S7 = 4'd7,
                         S8  = 4'd8,  S9  = 4'd9,  S10 = 4'd10,
                         S11 = 4'd11;

  logic [3:0] state_d;
  logic       load;
  logic       bad_next;
  logic       retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      current_state <= S0;
      illegal_state <= 1'b0;
    end else begin
      current_state <= state_d;
      if (bad_next) illegal_state <= 1'b1;
    end
  end

  always_comb begin
    load = 1'b1;
    if (current_state == S11)
      load = 1'b0;
    else if ((current_state == S0 || current_state == S3 || current_state == S5) && !mem_ready)
      load = 1'b0;
    bad_next = load && (next_state > S11);
    state_d  = current_state;
    if (bad_next)
      state_d = S11;
    else if (load)
      state_d = next_state;
    retire = load && (next_state == S0) &&
             (current_state inside {S4, S5, S7, S8, S9, S10});
  end

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    ab_write      = 1'b0;
    aluout_write  = 1'b0;
    alu_src_b     = 1'b0;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    halted        = 1'b0;
    case (current_state)
      S0: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S1: ab_write = 1'b1;
      S2: begin
        alu_src_b    = 1'b1;
        aluout_write = 1'b1;
      end
      S3: begin
        mem_read  = 1'b1;
        iord      = 1'b1;
        mdr_write = mem_ready;
      end
      S4: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S5: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S6: begin
        alu_op       = 2'b10;
        aluout_write = 1'b1;
      end
      S7: reg_write = 1'b1;
      S8: begin
        alu_op    = 2'b11;
        reg_write = 1'b1;
      end
      S9: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      S10: begin
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      S11: halted = 1'b1;
      default: ;
    endcase
  end

`ifdef SEQ_PERF_CNT_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (current_state != S11 && cycle_cnt != {CNT_W{1'b1}})
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire && instr_cnt != {CNT_W{1'b1}})
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign cycle_cnt     = '0;
  assign instr_cnt     = '0;
`endif

endmodule

// File: tb/tb_controller_state_sequencer.sv
// Directed and random checks of controller_state_sequencer against a
// set-based behavioural model of state sequencing, strobes and counters.
module tb_controller_state_sequencer;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [3:0]       next_state;
  logic             mem_ready;
  logic [3:0]       current_state;
  logic             mem_read, mem_write, iord, ir_write, mdr_write, ab_write;
  logic             aluout_write, alu_src_b, reg_write, mem_to_reg;
  logic             pc_write, pc_write_cond, halted, illegal_state;
  logic [1:0]       alu_op, pc_src;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  int total = 0;
  int bad   = 0;

  int m_st;
  bit m_ill;
  int m_cyc;
  int m_ins;

  controller_state_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .next_state(next_state), .mem_ready(mem_ready),
    .current_state(current_state), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .mdr_write(mdr_write), .ab_write(ab_write),
    .aluout_write(aluout_write), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_src(pc_src), .halted(halted),
    .illegal_state(illegal_state), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit mr;
    int e_aluop, e_pcsrc;
    mr = mem_ready;
    e_aluop = (m_st == 6) ? 2 : (m_st == 8) ? 3 : (m_st == 10) ? 1 : 0;
    e_pcsrc = (m_st == 9) ? 2 : (m_st == 10) ? 1 : 0;
    chk("current_state", 32'(current_state), 32'(m_st));
    chk("mem_read",      32'(mem_read),      32'(m_st inside {0, 3}));
    chk("mem_write",     32'(mem_write),     32'(m_st == 5));
    chk("iord",          32'(iord),          32'(m_st inside {3, 5}));
    chk("ir_write",      32'(ir_write),      32'(m_st == 0 && mr));
    chk("mdr_write",     32'(mdr_write),     32'(m_st == 3 && mr));
    chk("ab_write",      32'(ab_write),      32'(m_st == 1));
    chk("aluout_write",  32'(aluout_write),  32'(m_st inside {2, 6}));
    chk("alu_src_b",     32'(alu_src_b),     32'(m_st == 2));
    chk("alu_op",        32'(alu_op),        32'(e_aluop));
    chk("reg_write",     32'(reg_write),     32'(m_st inside {4, 7, 8}));
    chk("mem_to_reg",    32'(mem_to_reg),    32'(m_st == 4));
    chk("pc_write",      32'(pc_write),      32'((m_st == 0 && mr) || m_st == 9));
    chk("pc_write_cond", 32'(pc_write_cond), 32'(m_st == 10));
    chk("pc_src",        32'(pc_src),        32'(e_pcsrc));
    chk("halted",        32'(halted),        32'(m_st == 11));
    chk("illegal_state", 32'(illegal_state), 32'(m_ill));
    chk("cycle_cnt",     32'(cycle_cnt),     PERF ? 32'(m_cyc) : 32'd0);
    chk("instr_cnt",     32'(instr_cnt),     PERF ? 32'(m_ins) : 32'd0);
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input int ns, input bit mr);
    int old;
    old = m_st;
    if (old != 11) begin
      if (m_cyc < CMAX) m_cyc++;
      if (!(old inside {0, 3, 5} && !mr)) begin
        if (ns > 11) begin
          m_st  = 11;
          m_ill = 1'b1;
        end else begin
          if (ns == 0 && old inside {4, 5, 7, 8, 9, 10} && m_ins < CMAX) m_ins++;
          m_st = ns;
        end
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input int ns, input bit mr);
    next_state = 4'(ns);
    mem_ready  = mr;
    #1;
    check_all();
    @(posedge clk);
    model_edge(ns, mr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    m_st = 0; m_ill = 1'b0; m_cyc = 0; m_ins = 0;
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    next_state = 4'd1;
    mem_ready = 1'b1;
    m_st = 0; m_ill = 1'b0; m_cyc = 0; m_ins = 0;
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // ADD: S0 -> S1 -> S6 -> S7 -> S0
    step(1, 1); step(6, 1); step(7, 1); step(0, 1);
    #1; check_all();
    chk("add_instr_cnt", 32'(instr_cnt), PERF ? 32'd1 : 32'd0);
    chk("add_cycle_cnt", 32'(cycle_cnt), PERF ? 32'd4 : 32'd0);

    // LW with a three-cycle memory stall in S3
    step(1, 1); step(2, 1); step(3, 1);
    step(4, 0); step(4, 0); step(4, 0); step(4, 1);
    step(0, 1);

    // SW stalled in S5, reset pulsed mid-stall
    step(1, 1); step(2, 1); step(5, 1);
    step(0, 0); step(0, 0);
    do_reset();
    chk("rst_mem_write", 32'(mem_write), 32'd0);

    // Illegal next_state from S1, then S11 is sticky
    step(1, 1); step(15, 1);
    for (int i = 0; i < 5; i++) step($urandom_range(0, 15), $urandom_range(0, 1));
    chk("halt_sticky", 32'(halted), 32'd1);
    do_reset();

    // Single-cycle retire loop (jump) past counter saturation
    for (int i = 0; i < 20; i++) begin
      step(9, 1);
      step(0, 1);
    end
    #1;
    chk("sat_instr_cnt", 32'(instr_cnt), PERF ? 32'(CMAX) : 32'd0);
    do_reset();

    // Random next_state / mem_ready traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ((m_st == 11 && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0)
        do_reset();
      else
        step(($urandom_range(0, 15) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 11),
             $urandom_range(0, 3) != 0);
    end
    #1; check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
